shared_ram_arb: RTL and testbench

// Three-way arbiter for the single-port 32-bit shared packet RAM (1-cycle synchronous read).
// USB engine (byte port, real-time, never stalled) has absolute priority.
// CPU and DMA word ports (valid/ready) share leftover cycles round-robin.
// Per-port wait counters flag starvation for firmware debug.

---
 rtl/shared_ram_arb.sv | 155 +++++++++++++++
 tb/tb_shared_ram_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_ram_arb.sv
// Three-way arbiter for the single-port shared packet RAM: the USB byte port always wins,
// and the CPU and DMA word ports share the remaining cycles round-robin with starvation flags.
module shared_ram_arb #(
  parameter int unsigned AW           = 10,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          usb_ren,
  input  logic          usb_wen,
  input  logic [AW-1:0] usb_addr,
  input  logic [7:0]    usb_wdata,
  output logic [7:0]    usb_rdata,
  input  logic          cpu_valid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wstrb,
  output logic          cpu_ready,
  output logic [31:0]   cpu_rdata,
  input  logic          dma_valid,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  input  logic [3:0]    dma_wstrb,
  output logic          dma_ready,
  output logic [31:0]   dma_rdata,
  output logic          ram_ce,
  output logic [AW-3:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_wstrb,
  input  logic [31:0]   ram_rdata,
  output logic [1:0]    starve,
  input  logic          starve_clr
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {RR_CPU, RR_DMA} rr_t;

  rr_t        rr_q, rr_d;
  logic       usb_act, usb_rd;
  logic       cpu_elig, dma_elig, cpu_gnt, dma_gnt;
  logic       cpu_inflight, dma_inflight;
  logic       usb_rd_pend;
  logic [1:0] usb_lane;
  logic [7:0] cpu_wait_q, cpu_wait_d, dma_wait_q, dma_wait_d;
  logic [1:0] starve_d;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[1:0], dma_addr[1:0]};

  assign usb_act  = usb_ren | usb_wen;
  // A simultaneous read+write is a write: no lane capture, no read data.
  assign usb_rd   = usb_ren & ~usb_wen;
  assign cpu_elig = cpu_valid & ~cpu_inflight;
  assign dma_elig = dma_valid & ~dma_inflight;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    rr_d    = rr_q;
    if (!usb_act) begin
      if (cpu_elig && dma_elig) begin
        if (rr_q == RR_CPU) begin
          cpu_gnt = 1'b1;
          rr_d    = RR_DMA;
        end else begin
          dma_gnt = 1'b1;
          rr_d    = RR_CPU;
        end
      end else begin
        cpu_gnt = cpu_elig;
        dma_gnt = dma_elig;
      end
    end
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = '0;
    if (usb_act) begin
      ram_ce    = 1'b1;
      ram_addr  = usb_addr[AW-1:2];
      ram_wdata = {4{usb_wdata}};
      ram_wstrb = usb_wen ? 4'(4'b0001 << usb_addr[1:0]) : 4'b0000;
    end else if (cpu_gnt) begin
      ram_ce    = 1'b1;
      ram_addr  = cpu_addr[AW-1:2];
      ram_wdata = cpu_wdata;
      ram_wstrb = cpu_wstrb;
    end else if (dma_gnt) begin
      ram_ce    = 1'b1;
      ram_addr  = dma_addr[AW-1:2];
      ram_wdata = dma_wdata;
      ram_wstrb = dma_wstrb;
    end
  end

  // Wait counters saturate at LIMIT; the sticky flag is raised as the counter arrives there.
  always_comb begin
    cpu_wait_d = cpu_wait_q;
    dma_wait_d = dma_wait_q;
    starve_d   = starve;
    if (starve_clr) begin
      cpu_wait_d = '0;
      dma_wait_d = '0;
      starve_d   = '0;
    end else begin
      if (cpu_gnt)
        cpu_wait_d = '0;
      else if (cpu_valid && cpu_wait_q != LIMIT)
        cpu_wait_d = cpu_wait_q + 8'd1;
      if (dma_gnt)
        dma_wait_d = '0;
      else if (dma_valid && dma_wait_q != LIMIT)
        dma_wait_d = dma_wait_q + 8'd1;
      if (cpu_wait_d == LIMIT) starve_d[0] = 1'b1;
      if (dma_wait_d == LIMIT) starve_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= RR_CPU;
      cpu_inflight <= 1'b0;
      dma_inflight <= 1'b0;
      cpu_wait_q   <= '0;
      dma_wait_q   <= '0;
      starve       <= '0;
      usb_rd_pend  <= 1'b0;
      usb_lane     <= '0;
    end else begin
      rr_q         <= rr_d;
      cpu_inflight <= cpu_gnt;
      dma_inflight <= dma_gnt;
      cpu_wait_q   <= cpu_wait_d;
      dma_wait_q   <= dma_wait_d;
      starve       <= starve_d;
      usb_rd_pend  <= usb_rd;
      if (usb_rd) usb_lane <= usb_addr[1:0];
    end
  end

  assign cpu_ready = cpu_inflight;
  assign dma_ready = dma_inflight;
  assign cpu_rdata = ram_rdata;
  assign dma_rdata = ram_rdata;

  always_comb begin
    usb_rdata = '0;
    if (usb_rd_pend) usb_rdata = ram_rdata[{usb_lane, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_shared_ram_arb.sv
// Directed bench for shared_ram_arb: per-cycle vector table plus hand-written
// starvation and reset-mid-access sequences, with a behavioural RAM attached.
module tb_shared_ram_arb;

  logic        clk, rst;
  logic        usb_ren, usb_wen;
  logic [9:0]  usb_addr;
  logic [7:0]  usb_wdata, usb_rdata;
  logic        cpu_valid, cpu_ready;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        dma_valid, dma_ready;
  logic [9:0]  dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic [3:0]  dma_wstrb;
  logic        ram_ce;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_wstrb;
  logic [1:0]  starve;
  logic        starve_clr;

  int checks = 0;
  int errors = 0;

  shared_ram_arb #(.AW(10), .STARVE_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .usb_ren(usb_ren), .usb_wen(usb_wen), .usb_addr(usb_addr),
    .usb_wdata(usb_wdata), .usb_rdata(usb_rdata),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_wstrb(dma_wstrb), .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .ram_ce(ram_ce), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata),
    .starve(starve), .starve_clr(starve_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, read-before-write, 1-cycle read latency.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  typedef struct {
    logic        ur, uw;
    logic [9:0]  ua;
    logic [7:0]  ud;
    logic        cv;
    logic [9:0]  ca;
    logic [31:0] cd;
    logic [3:0]  cs;
    logic        dv;
    logic [9:0]  da;
    logic [31:0] dd;
    logic [3:0]  ds;
    logic        e_ce;
    logic [7:0]  e_addr;
    logic [3:0]  e_wstrb;
    logic [7:0]  e_urd;
    logic        e_crdy;
    logic [31:0] e_crd;
    logic        e_drdy;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic [31:0] ur, uw, ua, ud,
    input logic [31:0] cv, ca, cd, cs,
    input logic [31:0] dv, da, dd, ds,
    input logic [31:0] e_ce, e_addr, e_wstrb, e_urd,
    input logic [31:0] e_crdy, e_crd, e_drdy, e_drd);
    vec_t v;
    v.ur = ur[0]; v.uw = uw[0]; v.ua = ua[9:0]; v.ud = ud[7:0];
    v.cv = cv[0]; v.ca = ca[9:0]; v.cd = cd; v.cs = cs[3:0];
    v.dv = dv[0]; v.da = da[9:0]; v.dd = dd; v.ds = ds[3:0];
    v.e_ce = e_ce[0]; v.e_addr = e_addr[7:0]; v.e_wstrb = e_wstrb[3:0];
    v.e_urd = e_urd[7:0]; v.e_crdy = e_crdy[0]; v.e_crd = e_crd;
    v.e_drdy = e_drdy[0]; v.e_drd = e_drd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    usb_ren = 0; usb_wen = 0; usb_addr = '0; usb_wdata = '0;
    cpu_valid = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    dma_valid = 0; dma_addr = '0; dma_wdata = '0; dma_wstrb = '0;
    starve_clr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_rdata = '0;
    rst = 1;
    idle_inputs();

    //  ur uw ua     ud     cv ca     cd            cs      dv da     dd            ds       ce addr wstrb   urd     crdy crd           drdy drd
    add(0, 0, 0,     0,     0, 0,     0,            0,      0, 0,     0,            0,       0, 0,   0,      0,      0, 0,            0, 0);            // reset state
    add(0, 1, 'h005, 'hA5,  0, 0,     0,            0,      0, 0,     0,            0,       1, 1,   4'b0010, 0,     0, 0,            0, 0);            // usb write lane 1
    add(1, 0, 'h005, 0,     0, 0,     0,            0,      0, 0,     0,            0,       1, 1,   0,      0,      0, 0,            0, 0);
    add(1, 0, 'h004, 0,     0, 0,     0,            0,      0, 0,     0,            0,       1, 1,   0,      'hA5,   0, 0,            0, 0);            // back-to-back reads
    add(0, 0, 0,     0,     0, 0,     0,            0,      0, 0,     0,            0,       0, 0,   0,      'h00,   0, 0,            0, 0);
    add(0, 0, 0,     0,     1, 'h010, 'hDEADBEEF,   'hF,    0, 0,     0,            0,       1, 4,   'hF,    0,      0, 0,            0, 0);            // cpu write
    add(0, 0, 0,     0,     1, 'h010, 'hDEADBEEF,   'hF,    0, 0,     0,            0,       0, 0,   0,      0,      1, 0,            0, 0);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      0, 0,     0,            0,       1, 4,   0,      0,      0, 0,            0, 0);            // cpu read
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      0, 0,     0,            0,       0, 0,   0,      0,      1, 'hDEADBEEF,   0, 0);
    add(1, 0, 0,     0,     1, 'h010, 0,            0,      0, 0,     0,            0,       1, 0,   0,      0,      0, 0,            0, 0);            // usb blocks cpu x3
    add(1, 0, 0,     0,     1, 'h010, 0,            0,      0, 0,     0,            0,       1, 0,   0,      0,      0, 0,            0, 0);
    add(1, 0, 0,     0,     1, 'h010, 0,            0,      0, 0,     0,            0,       1, 0,   0,      0,      0, 0,            0, 0);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      0, 0,     0,            0,       1, 4,   0,      0,      0, 0,            0, 0);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      0, 0,     0,            0,       0, 0,   0,      0,      1, 'hDEADBEEF,   0, 0);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      1, 'h004, 0,            0,       1, 4,   0,      0,      0, 0,            0, 0);            // round robin
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      1, 'h004, 0,            0,       1, 1,   0,      0,      1, 'hDEADBEEF,   0, 0);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      1, 'h004, 0,            0,       1, 4,   0,      0,      0, 0,            1, 'h0000A500);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      1, 'h004, 0,            0,       1, 1,   0,      0,      1, 'hDEADBEEF,   0, 0);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      1, 'h004, 0,            0,       1, 4,   0,      0,      0, 0,            1, 'h0000A500);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      1, 'h004, 0,            0,       1, 1,   0,      0,      1, 'hDEADBEEF,   0, 0);
    add(0, 0, 0,     0,     0, 0,     0,            0,      0, 0,     0,            0,       0, 0,   0,      0,      0, 0,            1, 'h0000A500);
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      1, 'h004, 0,            0,       1, 1,   0,      0,      0, 0,            0, 0);            // rr now favours dma
    add(0, 0, 0,     0,     1, 'h010, 0,            0,      1, 'h004, 0,            0,       1, 4,   0,      0,      0, 0,            1, 'h0000A500);
    add(0, 0, 0,     0,     0, 0,     0,            0,      0, 0,     0,            0,       0, 0,   0,      0,      1, 'hDEADBEEF,   0, 0);
    add(0, 0, 0,     0,     0, 0,     0,            0,      1, 'h008, 'h11223344,   4'b0101, 1, 2,   4'b0101, 0,     0, 0,            0, 0);            // dma partial write
    add(0, 0, 0,     0,     0, 0,     0,            0,      1, 'h008, 'h11223344,   4'b0101, 0, 0,   0,      0,      0, 0,            1, 0);
    add(0, 0, 0,     0,     0, 0,     0,            0,      1, 'h008, 0,            0,       1, 2,   0,      0,      0, 0,            0, 0);
    add(0, 0, 0,     0,     0, 0,     0,            0,      1, 'h008, 0,            0,       0, 0,   0,      0,      0, 0,            1, 'h00220044);
    add(0, 0, 0,     0,     0, 0,     0,            0,      0, 0,     0,            0,       0, 0,   0,      0,      0, 0,            0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk); #1;
      usb_ren = v.ur; usb_wen = v.uw; usb_addr = v.ua; usb_wdata = v.ud;
      cpu_valid = v.cv; cpu_addr = v.ca; cpu_wdata = v.cd; cpu_wstrb = v.cs;
      dma_valid = v.dv; dma_addr = v.da; dma_wdata = v.dd; dma_wstrb = v.ds;
      @(negedge clk);
      chk($sformatf("v%0d ram_ce", i), 32'(ram_ce), 32'(v.e_ce));
      if (v.e_ce) begin
        chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(v.e_addr));
        chk($sformatf("v%0d ram_wstrb", i), 32'(ram_wstrb), 32'(v.e_wstrb));
      end
      chk($sformatf("v%0d usb_rdata", i), 32'(usb_rdata), 32'(v.e_urd));
      chk($sformatf("v%0d cpu_ready", i), 32'(cpu_ready), 32'(v.e_crdy));
      chk($sformatf("v%0d dma_ready", i), 32'(dma_ready), 32'(v.e_drdy));
      if (v.e_crdy) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, v.e_crd);
      if (v.e_drdy) chk($sformatf("v%0d dma_rdata", i), dma_rdata, v.e_drd);
      chk($sformatf("v%0d starve", i), 32'(starve), 32'(0));
    end

    // Starvation: USB holds the RAM for 20 cycles while DMA waits.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      usb_ren = 1; usb_addr = '0;
      dma_valid = 1; dma_addr = 10'h008; dma_wstrb = '0;
      @(negedge clk);
      chk($sformatf("starve c%0d", k), 32'(starve), (k >= 17) ? 32'(2'b10) : 32'(0));
      chk($sformatf("dma_ready c%0d", k), 32'(dma_ready), 32'(0));
    end
    @(posedge clk); #1;
    usb_ren = 0;
    @(negedge clk);
    chk("starve dma grant ce", 32'(ram_ce), 32'(1));
    chk("starve dma grant addr", 32'(ram_addr), 32'(2));
    chk("starve sticky", 32'(starve), 32'(2'b10));
    @(posedge clk); #1;
    dma_valid = 0; starve_clr = 1;
    @(negedge clk);
    chk("starve dma_ready", 32'(dma_ready), 32'(1));
    chk("starve dma_rdata", dma_rdata, 32'h00220044);
    @(posedge clk); #1;
    starve_clr = 0;
    @(negedge clk);
    chk("starve cleared", 32'(starve), 32'(0));

    // Reset lands in the cycle a CPU read is granted.
    @(posedge clk); #1;
    rst = 1; cpu_valid = 1; cpu_addr = 10'h010; cpu_wstrb = '0;
    @(negedge clk);
    chk("rst grant ce", 32'(ram_ce), 32'(1));
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst cpu_ready", 32'(cpu_ready), 32'(0));
    chk("rst regrant ce", 32'(ram_ce), 32'(1));
    chk("rst regrant addr", 32'(ram_addr), 32'(4));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst done ready", 32'(cpu_ready), 32'(1));
    chk("rst done rdata", cpu_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    cpu_valid = 0;
    @(negedge clk);
    chk("rst idle ready", 32'(cpu_ready), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
